// File: rtl/instr_fetch_buffer.sv
// Instruction fetch stage: sequences word fetches over req/ack into a 2-entry
// {pc, word} prefetch buffer whose head is presented as ir to decode.
module instr_fetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] STALE = 2'd2;

    logic [1:0]  state;
    logic [31:0] fetch_pc;
    logic [31:0] pc_q   [2];
    logic [31:0] word_q [2];
    logic        head;
    logic        tail;
    logic [1:0]  count;

    logic        pop;
    logic        push;
    logic [1:0]  count_nxt;
    logic        can_req;
    logic [31:0] fetch_pc_inc;
    logic [31:0] redirect_addr;

    assign ir_valid      = (count != 2'd0);
    assign ir            = word_q[head];
    assign ir_pc         = pc_q[head];

    assign pop           = ir_valid & ir_ready & ~redirect;
    assign push          = imem_ack & (state == BUSY) & ~redirect;
    assign count_nxt     = count + {1'b0, push} - {1'b0, pop};
    // An outstanding request holds a slot, so a new one needs a free slot left over.
    assign can_req       = (count_nxt < 2'd2);
    assign fetch_pc_inc  = fetch_pc + 32'd4;
    assign redirect_addr = redirect_pc & ~32'h3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= 32'h0;
            head      <= 1'b0;
            tail      <= 1'b0;
            count     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                pc_q[i]   <= 32'h0;
                word_q[i] <= 32'h0;
            end
        end else if (redirect) begin
            count    <= 2'd0;
            head     <= 1'b0;
            tail     <= 1'b0;
            fetch_pc <= redirect_addr;
            case (state)
                IDLE: begin
                    state     <= BUSY;
                    imem_req  <= 1'b1;
                    imem_addr <= redirect_addr;
                end
                BUSY, STALE: begin
                    // A live request is never abandoned; its data is dropped on arrival.
                    if (imem_ack) begin
                        state     <= BUSY;
                        imem_req  <= 1'b1;
                        imem_addr <= redirect_addr;
                    end else begin
                        state <= STALE;
                    end
                end
                default: state <= IDLE;
            endcase
        end else begin
            if (push) begin
                pc_q[tail]   <= fetch_pc;
                word_q[tail] <= imem_rdata;
                tail         <= ~tail;
                fetch_pc     <= fetch_pc_inc;
            end
            if (pop) begin
                head <= ~head;
            end
            count <= count_nxt;

            case (state)
                IDLE: begin
                    if (can_req) begin
                        state     <= BUSY;
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                    end
                end
                BUSY: begin
                    if (imem_ack) begin
                        if (can_req) begin
                            imem_addr <= fetch_pc_inc;
                        end else begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                STALE: begin
                    if (imem_ack) begin
                        if (can_req) begin
                            state     <= BUSY;
                            imem_addr <= fetch_pc;
                        end else begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer: table-driven stream/redirect vectors
// plus hand-written backpressure, wait-state, redirect and reset sequences.
module tb_instr_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic        man_mode = 1'b0;
    logic        man_ack = 1'b0;
    int          wait_states = 0;
    int          wait_cnt = 0;
    int          ack_cnt = 0;

    int          n_chk = 0;
    int          n_fail = 0;

    localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;

    always #5 clk = ~clk;

    // Memory model: data is a function of address; ack either scripted or after wait_states cycles.
    assign imem_rdata = imem_addr ^ XOR_PAT;
    assign imem_ack   = imem_req && (man_mode ? man_ack : (wait_cnt >= wait_states));

    always @(posedge clk) begin
        wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;
        if (imem_ack) ack_cnt <= ack_cnt + 1;
    end

    instr_fetch_buffer #(.RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        vld;
        logic [31:0] pc;
        logic        req;
        logic [31:0] addr;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic vld, input logic [31:0] pc,
                             input logic req, input logic [31:0] addr);
        chk1({tag, " ir_valid"}, ir_valid, vld);
        if (vld) begin
            chk32({tag, " ir_pc"}, ir_pc, pc);
            chk32({tag, " ir"}, ir, pc ^ XOR_PAT);
        end
        chk1({tag, " imem_req"}, imem_req, req);
        if (req) chk32({tag, " imem_addr"}, imem_addr, addr);
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        redirect = 1'b0;
        man_ack  = 1'b0;
        tick();
        tick();
    endtask

    vec_t vt[9];

    initial begin
        vt[0] = '{1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 32'h100};
        vt[1] = '{1'b1, 1'b0, 32'h0,    1'b1, 32'h100,  1'b1, 32'h104};
        vt[2] = '{1'b1, 1'b0, 32'h0,    1'b1, 32'h104,  1'b1, 32'h108};
        vt[3] = '{1'b1, 1'b0, 32'h0,    1'b1, 32'h108,  1'b1, 32'h10C};
        vt[4] = '{1'b1, 1'b0, 32'h0,    1'b1, 32'h10C,  1'b1, 32'h110};
        vt[5] = '{1'b1, 1'b0, 32'h0,    1'b1, 32'h110,  1'b1, 32'h114};
        vt[6] = '{1'b1, 1'b1, 32'h2003, 1'b0, 32'h0,    1'b1, 32'h2000};
        vt[7] = '{1'b1, 1'b0, 32'h0,    1'b1, 32'h2000, 1'b1, 32'h2004};
        vt[8] = '{1'b1, 1'b0, 32'h0,    1'b1, 32'h2004, 1'b1, 32'h2008};

        // Reset values
        apply_reset();
        chk1("reset imem_req", imem_req, 1'b0);
        chk32("reset imem_addr", imem_addr, 32'h0);
        chk1("reset ir_valid", ir_valid, 1'b0);
        chk32("reset ir", ir, 32'h0);
        chk32("reset ir_pc", ir_pc, 32'h0);

        // Zero-wait stream then redirect on an ack cycle
        man_mode = 1'b0;
        wait_states = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            ir_ready    = vt[i].rdy;
            redirect    = vt[i].redir;
            redirect_pc = vt[i].rpc;
            tick();
            check_out($sformatf("vec%0d", i), vt[i].vld, vt[i].pc, vt[i].req, vt[i].addr);
        end
        redirect = 1'b0;

        // Backpressure: two words buffered, then req drops until a pop
        begin
            int acks0;
            apply_reset();
            ir_ready = 1'b0;
            acks0 = ack_cnt;
            rst_n = 1'b1;
            tick();
            check_out("bp e1", 1'b0, 32'h0, 1'b1, 32'h100);
            tick();
            check_out("bp e2", 1'b1, 32'h100, 1'b1, 32'h104);
            tick();
            check_out("bp e3", 1'b1, 32'h100, 1'b0, 32'h0);
            tick();
            check_out("bp e4", 1'b1, 32'h100, 1'b0, 32'h0);
            chk32("bp ack count", ack_cnt - acks0, 32'd2);
            ir_ready = 1'b1;
            tick();
            check_out("bp restart", 1'b1, 32'h104, 1'b1, 32'h108);
        end

        // Wait states: ack every third cycle
        begin
            logic [31:0] exp_pc;
            logic        prev_req;
            logic        prev_ack;
            logic [31:0] prev_addr;
            int          pops;
            apply_reset();
            wait_states = 2;
            ir_ready = 1'b1;
            rst_n = 1'b1;
            exp_pc = 32'h100;
            prev_req = 1'b0;
            prev_ack = 1'b0;
            prev_addr = 32'h0;
            pops = 0;
            for (int c = 0; c < 45; c++) begin
                tick();
                if (prev_req && !prev_ack && imem_req)
                    chk32("ws addr stable", imem_addr, prev_addr);
                if (ir_valid && ir_ready) begin
                    chk32("ws ir_pc", ir_pc, exp_pc);
                    chk32("ws ir", ir, exp_pc ^ XOR_PAT);
                    exp_pc = exp_pc + 32'd4;
                    pops++;
                end
                prev_req  = imem_req;
                prev_ack  = imem_ack;
                prev_addr = imem_addr;
            end
            chk1("ws pop count", pops >= 12, 1'b1);
            wait_states = 0;
        end

        // Redirect mid-request with ack delayed two cycles
        apply_reset();
        man_mode = 1'b1;
        ir_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        check_out("rm e1", 1'b0, 32'h0, 1'b1, 32'h100);
        redirect = 1'b1;
        redirect_pc = 32'h2003;
        tick();
        redirect = 1'b0;
        check_out("rm stale1", 1'b0, 32'h0, 1'b1, 32'h100);
        tick();
        check_out("rm stale2", 1'b0, 32'h0, 1'b1, 32'h100);
        man_ack = 1'b1;
        tick();
        check_out("rm drop", 1'b0, 32'h0, 1'b1, 32'h2000);
        tick();
        check_out("rm first", 1'b1, 32'h2000, 1'b1, 32'h2004);
        man_ack = 1'b0;

        // Redirect coinciding with an ack while the buffer is fully reserved
        apply_reset();
        man_mode = 1'b1;
        ir_ready = 1'b0;
        rst_n = 1'b1;
        tick();
        man_ack = 1'b1;
        tick();
        check_out("ra fill", 1'b1, 32'h100, 1'b1, 32'h104);
        redirect = 1'b1;
        redirect_pc = 32'h3000;
        tick();
        redirect = 1'b0;
        check_out("ra flush", 1'b0, 32'h0, 1'b1, 32'h3000);
        ir_ready = 1'b1;
        tick();
        check_out("ra first", 1'b1, 32'h3000, 1'b1, 32'h3004);
        tick();
        check_out("ra second", 1'b1, 32'h3004, 1'b1, 32'h3008);

        // Reset mid-operation: BUSY with one entry, ack arriving during reset
        apply_reset();
        man_mode = 1'b1;
        man_ack = 1'b0;
        ir_ready = 1'b0;
        rst_n = 1'b1;
        tick();
        man_ack = 1'b1;
        tick();
        check_out("rr busy", 1'b1, 32'h100, 1'b1, 32'h104);
        rst_n = 1'b0;
        tick();
        chk1("rr imem_req", imem_req, 1'b0);
        chk32("rr imem_addr", imem_addr, 32'h0);
        chk1("rr ir_valid", ir_valid, 1'b0);
        chk32("rr ir", ir, 32'h0);
        chk32("rr ir_pc", ir_pc, 32'h0);
        rst_n = 1'b1;
        tick();
        check_out("rr restart", 1'b0, 32'h0, 1'b1, 32'h100);
        tick();
        check_out("rr first", 1'b1, 32'h100, 1'b1, 32'h104);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
